// File: rtl/program_sequencer_pkg.sv
// Shared opcode constants and width helper for the program sequencer and its return stack.
package program_sequencer_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_JUMP = 3'b011;
    localparam logic [2:0] OP_REL  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Bits needed to encode values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/program_sequencer_pc_ret_stack.sv
// LIFO return-address stack: push writes at the fill level, top reads the entry just below it.
module pc_ret_stack
    import program_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             push_data,
    output logic [AW-1:0]             top,
    output logic [clog2(SD+1)-1:0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int CW = clog2(SD + 1);
    localparam int IW = clog2(SD);

    logic [AW-1:0] mem [SD];
    logic [CW-1:0] level;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = IW'(level);
    assign rd_idx = IW'(level - CW'(1));

    assign count = level;
    assign full  = (level == CW'(SD));
    assign empty = (level == '0);
    assign top   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            level       <= level + CW'(1);
        end else if (pop && !empty) begin
            level <= level - CW'(1);
        end
    end

    // Entries are don't-care after reset; only the fill level is cleared.

endmodule

// File: rtl/program_sequencer.sv
// Program counter with next-PC mux, return stack for CALL/RET and sticky stack-error flags.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2:0]                OP,
    input  logic                      E_PC,
    input  logic [AW-1:0]             OR,
    input  logic [AW-1:0]             dataBus_in,
    output logic [AW-1:0]             dataBus_out,
    output logic                      bus_drive,
    output logic [AW-1:0]             toAS,
    output logic [AW-1:0]             PC_reg,
    output logic [clog2(SD+1)-1:0]    sp_count,
    output logic                      ovf,
    output logic                      unf
);

    generate
        if (AW < 4 || AW > 16) begin : g_bad_aw
            $error("program_sequencer: AW out of range 4..16");
        end
        if (SD < 2 || SD > 16) begin : g_bad_sd
            $error("program_sequencer: SD out of range 2..16");
        end
    endgenerate

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;

    assign pc_inc = pc + AW'(1);

    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (OP)
            OP_HOLD, OP_RSVD: ;
            OP_INC:  pc_next = pc_inc;
            OP_LOAD: pc_next = dataBus_in;
            OP_JUMP: pc_next = OR;
            // Same-width modulo add is identical to adding the sign-extended offset.
            OP_REL:  pc_next = pc + dataBus_in;
            OP_CALL: begin
                if (stk_full) begin
                    set_ovf = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = OR;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    set_unf = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = stk_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc <= pc_next;
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
        end
    end

    pc_ret_stack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .count     (sp_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign PC_reg      = pc;
    assign toAS        = pc;
    assign bus_drive   = E_PC;
    assign dataBus_out = E_PC ? pc : '0;

endmodule

// File: tb/tb_program_sequencer.sv
// Table-driven bench for program_sequencer (AW=8, SD=4) with an expected-result queue.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic       e_pc;
    logic [7:0] or_v;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       bus_drive;
    logic [7:0] to_as;
    logic [7:0] pc_reg;
    logic [2:0] sp_count;
    logic       ovf;
    logic       unf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    program_sequencer #(
        .AW (8),
        .SD (4)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .OP          (op),
        .E_PC        (e_pc),
        .OR          (or_v),
        .dataBus_in  (db_in),
        .dataBus_out (db_out),
        .bus_drive   (bus_drive),
        .toAS        (to_as),
        .PC_reg      (pc_reg),
        .sp_count    (sp_count),
        .ovf         (ovf),
        .unf         (unf)
    );

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       e_pc;
        logic [7:0] or_v;
        logic [7:0] db;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } vec_t;

    typedef struct {
        string      name;
        logic       e_pc;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [2:0] o, logic e, logic [7:0] orv, logic [7:0] d,
                                logic [7:0] p, logic [2:0] s, logic ov, logic un);
        vec_t v;
        v.rst = r; v.op = o; v.e_pc = e; v.or_v = orv; v.db = d;
        v.pc = p; v.sp = s; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic check8(string name, logic [7:0] act, logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, compare #1 after the rising edge.
    task automatic step(string name, vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = v.rst; op = v.op; e_pc = v.e_pc; or_v = v.or_v; db_in = v.db;
        e.name = name; e.e_pc = v.e_pc; e.pc = v.pc; e.sp = v.sp; e.ovf = v.ovf; e.unf = v.unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check8({got.name, ".pc"},   pc_reg, got.pc);
        check8({got.name, ".toAS"}, to_as,  got.pc);
        check8({got.name, ".dbo"},  db_out, got.e_pc ? got.pc : 8'h00);
        check8({got.name, ".drv"},  {7'd0, bus_drive}, {7'd0, got.e_pc});
        check8({got.name, ".sp"},   {5'd0, sp_count},  {5'd0, got.sp});
        check8({got.name, ".ovf"},  {7'd0, ovf},       {7'd0, got.ovf});
        check8({got.name, ".unf"},  {7'd0, unf},       {7'd0, got.unf});
    endtask

    localparam logic [2:0] H = 3'b000, I = 3'b001, L = 3'b010, J = 3'b011,
                           R = 3'b100, C = 3'b101, T = 3'b110, X = 3'b111;

    initial begin
        rst = 1'b1; op = H; e_pc = 1'b0; or_v = '0; db_in = '0;

        //             rst op e  OR     db     PC     sp  ovf unf
        tbl.push_back(mk(1, H, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, I, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, I, 0, 8'h00, 8'h00, 8'h02, 0, 0, 0));
        tbl.push_back(mk(0, I, 0, 8'h00, 8'h00, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, H, 1, 8'h00, 8'h00, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, J, 0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(0, I, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, J, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, R, 0, 8'h00, 8'hF0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, J, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, R, 1, 8'h00, 8'h7F, 8'h8F, 0, 0, 0));
        tbl.push_back(mk(0, J, 0, 8'h05, 8'h00, 8'h05, 0, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h06, 0, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h20, 8'h00, 8'h20, 2, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h30, 8'h00, 8'h30, 3, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h50, 8'h00, 8'h50, 4, 0, 0));
        tbl.push_back(mk(0, C, 0, 8'h99, 8'h00, 8'h50, 4, 1, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h31, 3, 1, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h21, 2, 1, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h11, 1, 1, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h07, 0, 1, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h07, 0, 1, 1));
        tbl.push_back(mk(0, L, 0, 8'h00, 8'h33, 8'h33, 0, 1, 1));
        tbl.push_back(mk(0, C, 0, 8'h60, 8'h00, 8'h60, 1, 1, 1));
        tbl.push_back(mk(0, C, 0, 8'h70, 8'h00, 8'h70, 2, 1, 1));
        tbl.push_back(mk(1, C, 0, 8'h80, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, X, 1, 8'hAA, 8'h55, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, I, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, X, 0, 8'hAA, 8'h55, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, T, 0, 8'h00, 8'h00, 8'h01, 0, 0, 1));

        for (int unsigned k = 0; k < tbl.size(); k++) begin
            step($sformatf("tbl%0d", k), tbl[k]);
        end

        // CALL from FF pushes the wrapped return address 00; negative REL from 0 wraps to FF.
        step("wrap_rst",  mk(1, H, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step("wrap_jmp",  mk(0, J, 0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0));
        step("wrap_call", mk(0, C, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0));
        step("wrap_ret",  mk(0, T, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step("wrap_rel",  mk(0, R, 0, 8'h00, 8'hFF, 8'hFF, 0, 0, 0));

        // RET at reset edge is dropped, and the stack contents left behind are not reused.
        step("rr_call",   mk(0, C, 0, 8'h44, 8'h00, 8'h44, 1, 0, 0));
        step("rr_rst",    mk(1, T, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step("rr_ret",    mk(0, T, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1));
        step("rr_load",   mk(0, L, 1, 8'h00, 8'hC3, 8'hC3, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter AW, default 8: program-address and data-bus width in bits, legal range 4..16.
REQ-002 Parameter SD, default 4: return-stack depth in entries, legal range 2..16.
REQ-003 Port CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 Port RST  input  1: synchronous, active-high reset, sampled on rising CLK.
REQ-005 Port OP  input  3: operation code, sampled each rising CLK.
REQ-006 Port E_PC  input  1: bus-drive enable.
REQ-007 Port OR  input  AW: operand-register value; jump/call target.
REQ-008 Port dataBus_in  input  AW: bus value; load target or signed relative offset.
REQ-009 Port dataBus_out  output  AW: current PC when E_PC=1, else all zeros.
REQ-010 Port bus_drive  output  1: equals E_PC; tells the bus mux the sequencer is the source.
REQ-011 Port toAS  output  AW: current PC, always driven, to the address selector.
REQ-012 Port PC_reg  output  AW: registered program counter.
REQ-013 Port sp_count  output  clog2(SD+1): number of valid return-stack entries.
REQ-014 Port ovf  output  1: sticky return-stack overflow flag.
REQ-015 Port unf  output  1: sticky return-stack underflow flag.

Function
REQ-016 OP encoding: 000 HOLD, 001 INC, 010 LOAD (PC<=dataBus_in), 011 JUMP (PC<=OR), 100 REL (PC<=PC+sign-extended dataBus_in), 101 CALL, 110 RET, 111 reserved, treated as HOLD.
REQ-017 Every operation takes effect at the first rising CLK at which it is sampled; PC_reg, toAS and dataBus_out show the new value right after that edge.
REQ-018 INC and REL arithmetic is modulo 2^AW: PC=2^AW-1 with INC gives 0, and a negative REL offset below 0 wraps.
REQ-019 CALL, stack not full: push PC+1 (mod 2^AW), PC<=OR, sp_count+1, all in the same edge.
REQ-020 CALL, stack full (sp_count=SD): no push, stack contents unchanged, PC holds, ovf<=1.
REQ-021 RET, stack not empty: PC<=top entry, pop, sp_count-1.
REQ-022 RET, stack empty: PC holds, sp_count stays 0, unf<=1.
REQ-023 ovf and unf stay set until RST; they do not block later operations.
REQ-024 E_PC does not affect state; dataBus_out and bus_drive are combinational from E_PC and PC_reg.
REQ-025 Stack is LIFO: CALL A, CALL B, RET, RET returns to B+1, then A+1.

Reset
REQ-026 RST=1 at a rising CLK: PC_reg=0, sp_count=0, ovf=0, unf=0; stack entries are don't-care.
REQ-027 RST has priority over any OP in the same cycle, including a CALL or RET in progress.
REQ-028 The first OP after RST deasserts is honoured on the next edge; there are no wait cycles.

Structure
REQ-029 A shared package holds the OP code constants (OP_HOLD..OP_RET) and the clog2 helper; no literal opcodes appear in the RTL.
REQ-030 The return stack is the sub-module pc_ret_stack, parametrised by AW and SD:
- inputs: push, pop, push data;
- outputs: top, count, full, empty.
REQ-031 program_sequencer owns the PC register, the next-PC mux and the sticky flags.
REQ-032 The design has no latches and no initial blocks for state; reset is the only initialisation.

Verification
REQ-033 The bench covers the following directed scenarios, with AW=8 and SD=4:
- RST, then INC x3 -> PC_reg=3, toAS=3; E_PC=0 -> dataBus_out=0; E_PC=1 -> dataBus_out=3.
- PC=FF, INC -> PC=00; PC=10, REL with dataBus_in=F0 -> PC=00; PC=10, REL 7F -> PC=8F.
- PC=05, CALL OR=40 -> PC=40, sp_count=1; RET -> PC=06, sp_count=0.
- Four CALLs fill the stack, fifth CALL OR=99 -> PC unchanged, ovf=1, sp_count=4; four RETs return in LIFO order.
- RET with empty stack -> PC unchanged, unf=1; LOAD 33 afterwards -> PC=33, unf still 1.
- RST asserted together with CALL at sp_count=2 -> PC=0, sp_count=0, flags clear; OP=111 -> PC holds.
